// File: rtl/ret_stack.sv
// Hardware return-address stack: ring buffer with saturating count and sticky error flags.
// Optional macro RET_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of being dropped.
module ret_stack #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic                       err_clr,
    output logic [ADDR_W-1:0]          top_addr,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wp_q, wp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              we;
    logic [PW-1:0]     waddr;
    logic [PW-1:0]     top_idx;
    logic              is_empty;
    logic              is_full;

    assign top_idx  = wp_q - PW'(1);
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(DEPTH));

    assign top_addr  = is_empty ? '0 : mem_q[top_idx];
    assign empty     = is_empty;
    assign full      = is_full;
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // Next-state: pointer, count, flags and the single memory write port.
    always_comb begin
        wp_d  = wp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q & ~err_clr;
        unf_d = unf_q & ~err_clr;
        we    = 1'b0;
        waddr = wp_q;
        if (push && pop) begin
            if (!is_empty) begin
                we    = 1'b1;
                waddr = top_idx;
            end else begin
                we    = 1'b1;
                wp_d  = wp_q + PW'(1);
                cnt_d = cnt_q + CW'(1);
                unf_d = 1'b1;
            end
        end else if (push) begin
            if (!is_full) begin
                we    = 1'b1;
                wp_d  = wp_q + PW'(1);
                cnt_d = cnt_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
`ifdef RET_STACK_WRAP_EN
                we    = 1'b1;
                wp_d  = wp_q + PW'(1);
`endif
            end
        end else if (pop) begin
            if (!is_empty) begin
                wp_d  = wp_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage; contents need no reset, writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem_q[waddr] <= push_addr;
        end
    end

endmodule

// File: tb/tb_ret_stack.sv
// Directed test of ret_stack with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_ret_stack;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic        pop;
    logic [31:0] push_addr;
    logic        err_clr;
    logic [31:0] top_addr;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    ret_stack #(.ADDR_W(32), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .err_clr   (err_clr),
        .top_addr  (top_addr),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic pu, input logic po, input logic [31:0] a, input logic ec);
        @(negedge clk);
        push      = pu;
        pop       = po;
        push_addr = a;
        err_clr   = ec;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; push_addr = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_top", top_addr, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);

        // LIFO order
        cyc(1, 0, 32'h10, 0);
        cyc(1, 0, 32'h20, 0);
        cyc(1, 0, 32'h30, 0);
        cyc(0, 1, 0, 0);
        chk("lifo_count", count, 3);
        chk("lifo_pop1", top_addr, 32'h30);
        cyc(0, 1, 0, 0);
        chk("lifo_pop2", top_addr, 32'h20);
        cyc(0, 1, 0, 0);
        chk("lifo_pop3", top_addr, 32'h10);
        idle();
        chk("lifo_empty", empty, 1);
        chk("lifo_top0", top_addr, 0);

        // Underflow and err_clr
        cyc(0, 1, 0, 0);
        idle();
        chk("unf_count", count, 0);
        chk("unf_set", underflow, 1);
        cyc(0, 0, 0, 1);
        idle();
        chk("unf_clr", underflow, 0);
        cyc(0, 1, 0, 1);
        idle();
        chk("unf_wins", underflow, 1);
        cyc(0, 0, 0, 1);
        idle();

        // Overflow
        for (int i = 1; i <= 8; i++) cyc(1, 0, 32'(i), 0);
        idle();
        chk("ovf_full", full, 1);
        cyc(1, 0, 32'h9, 0);
        idle();
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 0, 0);
`ifdef RET_STACK_WRAP_EN
            chk($sformatf("ovf_pop%0d", k), top_addr, 32'(9 - k));
`else
            chk($sformatf("ovf_pop%0d", k), top_addr, 32'(8 - k));
`endif
        end
        idle();
        chk("ovf_empty", empty, 1);
        cyc(0, 0, 0, 1);
        idle();
        chk("ovf_clr", overflow, 0);

        // Simultaneous push and pop
        cyc(1, 0, 32'h10, 0);
        cyc(1, 0, 32'h20, 0);
        cyc(1, 1, 32'h99, 0);
        idle();
        chk("pp_count", count, 2);
        chk("pp_top", top_addr, 32'h99);
        chk("pp_nounf", underflow, 0);
        cyc(0, 1, 0, 0);
        idle();
        chk("pp_reveal", top_addr, 32'h10);
        chk("pp_count1", count, 1);
        cyc(0, 1, 0, 0);
        idle();
        chk("pp_empty", empty, 1);
        cyc(1, 1, 32'h44, 0);
        idle();
        chk("ppe_count", count, 1);
        chk("ppe_top", top_addr, 32'h44);
        chk("ppe_unf", underflow, 1);

        // Reset mid-operation
        cyc(0, 1, 0, 0);
        cyc(1, 0, 32'h10, 0);
        cyc(1, 0, 32'h20, 0);
        @(negedge clk);
        reset = 1'b1; push = 1'b1; pop = 1'b0; push_addr = 32'h30;
        @(negedge clk);
        reset = 1'b0; push = 1'b0;
        #1;
        chk("rmid_count", count, 0);
        chk("rmid_empty", empty, 1);
        chk("rmid_top", top_addr, 0);
        chk("rmid_unf", underflow, 0);
        cyc(1, 0, 32'h55, 0);
        idle();
        chk("rmid_push_top", top_addr, 32'h55);
        chk("rmid_push_cnt", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
